// File: rtl/huffman_pkg.sv
// Shared Huffman code table for the chunk encoder and the downstream decoder stage.
// Codes are stored left-aligned so the first bit on the wire is always the MSB.
package huffman_pkg;

   localparam int MAX_CODE = 9;
   localparam int CHUNK    = 4;
   localparam int LEN_W    = 3;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } enc_state_t;

   typedef struct packed {
      logic [MAX_CODE-1:0] code;
      logic [3:0]          len;
   } code_entry_t;

   // Indexed by the unsigned view of the signed symbol: 0..7 -> 0..+7, 8..15 -> -8..-1.
   localparam logic [MAX_CODE-1:0] CODE_TABLE [16] = '{
      9'b000000000, 9'b100000000, 9'b110000000, 9'b111000000,
      9'b111100000, 9'b111110000, 9'b111111000, 9'b111111100,
      9'b111111110, 9'b111111101, 9'b111111010, 9'b111110100,
      9'b111101000, 9'b111010000, 9'b110100000, 9'b101000000
   };

   localparam logic [3:0] LEN_TABLE [16] = '{
      4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
      4'd9, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3
   };

   function automatic code_entry_t lookup_code(input logic [3:0] sym);
      code_entry_t entry;
      entry.code = CODE_TABLE[sym];
      entry.len  = LEN_TABLE[sym];
      return entry;
   endfunction

endpackage

// File: rtl/huffman_code_rom.sv
// Combinational symbol-to-codeword lookup; code is left-aligned, len is 1..9.
module huffman_code_rom
   import huffman_pkg::*;
(
   input  logic [3:0]          sym,
   output logic [MAX_CODE-1:0] code,
   output logic [3:0]          len
);

   code_entry_t entry_s;

   // table lookup
   always_comb begin
      entry_s = lookup_code(sym);
      code    = entry_s.code;
      len     = entry_s.len;
   end

endmodule

// File: rtl/huffman_chunk_encoder.sv
// Huffman encoder: one symbol in, codeword out as CHUNK-bit beats with valid/ready.
// The residual register holds unsent bits left-aligned and shifts by CHUNK per beat.
module huffman_chunk_encoder #(
   parameter int MAX_CODE = huffman_pkg::MAX_CODE,
   parameter int CHUNK    = huffman_pkg::CHUNK,
   parameter int LEN_W    = huffman_pkg::LEN_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [CHUNK-1:0] m_bits,
   output logic [LEN_W-1:0] m_len,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last
);
   import huffman_pkg::*;

   enc_state_t          state_r, state_nx_s;
   logic [MAX_CODE-1:0] code_r, code_nx_s, rom_code_s;
   logic [3:0]          rem_r, rem_nx_s, rom_len_s;
   logic [CHUNK-1:0]    top_s;
   logic [LEN_W-1:0]    n_s;
   logic                last_s;

   huffman_code_rom u_rom (
      .sym  (s_data),
      .code (rom_code_s),
      .len  (rom_len_s)
   );

   // current chunk size and the top CHUNK bits of the residual
   always_comb begin
      top_s  = code_r[MAX_CODE-1 -: CHUNK];
      last_s = (rem_r <= 4'(CHUNK));
      if (last_s) begin
         n_s = rem_r[LEN_W-1:0];
      end else begin
         n_s = LEN_W'(CHUNK);
      end
   end

   // next-state, residual update and handshake outputs
   always_comb begin
      state_nx_s = state_r;
      code_nx_s  = code_r;
      rem_nx_s   = rem_r;
      s_ready    = 1'b0;
      m_valid    = 1'b0;
      m_bits     = '0;
      m_len      = '0;
      m_last     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            s_ready = 1'b1;
            if (s_valid) begin
               state_nx_s = ST_EMIT;
               code_nx_s  = rom_code_s;
               rem_nx_s   = rom_len_s;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_EMIT: begin
            m_valid = 1'b1;
            m_bits  = top_s >> (LEN_W'(CHUNK) - n_s);
            m_len   = n_s;
            m_last  = last_s;
            s_ready = last_s & m_ready;
            if (m_ready && !last_s) begin
               code_nx_s = code_r << CHUNK;
               rem_nx_s  = rem_r - 4'(CHUNK);
            end else if (m_ready && s_valid) begin
               code_nx_s = rom_code_s;
               rem_nx_s  = rom_len_s;
            end else if (m_ready) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_EMIT;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            code_nx_s  = '0;
            rem_nx_s   = '0;
         end
      endcase
   end

   // state and residual registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         code_r  <= '0;
         rem_r   <= '0;
      end else begin
         state_r <= state_nx_s;
         code_r  <= code_nx_s;
         rem_r   <= rem_nx_s;
      end
   end

endmodule

// File: tb/tb_huffman_chunk_encoder.sv
// Self-checking bench: directed scenarios plus random symbols against a bit-level
// codeword model, with a loopback decode of the emitted bit stream.
module tb_huffman_chunk_encoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] s_data = 4'd0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [3:0] m_bits;
   logic [2:0] m_len;
   logic       m_valid;
   logic       m_ready = 1'b1;
   logic       m_last;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      int bits;
      int len;
      int last;
   } beat_t;

   beat_t exp_q[$];
   int    sent_q[$];
   bit    stream_q[$];
   bit    collect = 1'b0;
   bit    rand_ready = 1'b0;

   huffman_chunk_encoder dut (
      .clk     (clk),
      .reset   (reset),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .m_bits  (m_bits),
      .m_len   (m_len),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_last  (m_last)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input int got, input int exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Codeword from the table's rule: |s| ones, a zero, then a sign bit (0 and -8 special).
   function automatic void push_beats(input int sym);
      bit    cw[$];
      int    k;
      beat_t b;
      if (sym == 0) begin
         cw.push_back(1'b0);
      end else begin
         k = (sym < 0) ? -sym : sym;
         for (int i = 0; i < k; i++) cw.push_back(1'b1);
         cw.push_back(1'b0);
         if (sym != -8) cw.push_back(sym < 0);
      end
      while (cw.size() > 0) begin
         b.bits = 0;
         b.len  = 0;
         while (cw.size() > 0 && b.len < 4) begin
            b.bits = b.bits * 2 + int'(cw.pop_front());
            b.len++;
         end
         b.last = (cw.size() == 0) ? 1 : 0;
         exp_q.push_back(b);
      end
   endfunction

   function automatic int to_sym(input logic [3:0] v);
      return int'($signed(v));
   endfunction

   // Monitor: compare every visible beat to the model, sampled mid-cycle.
   always @(negedge clk) begin
      beat_t b;
      if (!reset) begin
         check_value("m_valid_rule", int'(m_valid), (exp_q.size() != 0) ? 1 : 0);
         check_value("s_ready_rule", int'(s_ready), (!m_valid || (m_ready && m_last)) ? 1 : 0);
         if (m_valid && exp_q.size() != 0) begin
            b = exp_q[0];
            check_value("m_bits", int'(m_bits), b.bits);
            check_value("m_len", int'(m_len), b.len);
            check_value("m_last", int'(m_last), b.last);
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (collect) begin
               for (int i = 3; i >= 0; i--) begin
                  if (i < int'(m_len)) stream_q.push_back(m_bits[i]);
               end
            end
         end
         if (s_valid && s_ready) begin
            push_beats(to_sym(s_data));
            if (collect) sent_q.push_back(to_sym(s_data));
         end
      end
   end

   // random backpressure
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic drive_symbol(input int sym);
      int n;
      s_data  = 4'(sym);
      s_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!s_ready && n < 60);
      if (!s_ready) check_value("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   function automatic void decode_stream(output int dec[$]);
      int idx;
      int k;
      dec = {};
      idx = 0;
      while (idx < stream_q.size()) begin
         k = 0;
         while (idx < stream_q.size() && stream_q[idx] == 1'b1 && k < 8) begin
            k++;
            idx++;
         end
         idx++;
         if (k == 0) dec.push_back(0);
         else if (k == 8) dec.push_back(-8);
         else begin
            if (idx < stream_q.size() && stream_q[idx] == 1'b1) dec.push_back(-k);
            else dec.push_back(k);
            idx++;
         end
      end
   endfunction

   initial begin
      int dec[$];
      int n;
      int gap;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_value("rst_m_valid", int'(m_valid), 0);
      check_value("rst_m_bits", int'(m_bits), 0);
      check_value("rst_m_len", int'(m_len), 0);
      check_value("rst_m_last", int'(m_last), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_value("rst_s_ready", int'(s_ready), 1);

      // symbol 0: single one-bit beat, then idle
      @(posedge clk);
      #1;
      drive_symbol(0);
      @(negedge clk);
      check_value("t0_valid", int'(m_valid), 1);
      check_value("t0_len", int'(m_len), 1);
      @(negedge clk);
      check_value("t0_idle", int'(m_valid), 0);

      // -7: three beats, s_ready low until the last one
      @(posedge clk);
      #1;
      drive_symbol(-7);
      @(negedge clk);
      check_value("t7_b1_bits", int'(m_bits), 15);
      check_value("t7_b1_ready", int'(s_ready), 0);
      @(negedge clk);
      check_value("t7_b2_bits", int'(m_bits), 14);
      check_value("t7_b2_ready", int'(s_ready), 0);
      @(negedge clk);
      check_value("t7_b3_bits", int'(m_bits), 1);
      check_value("t7_b3_last", int'(m_last), 1);

      // +1 then -2 back-to-back with s_valid held
      @(posedge clk);
      #1;
      s_data  = 4'(1);
      s_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1 s_data = 4'(-2);
      @(negedge clk);
      check_value("b2b_bits1", int'(m_bits), 4);
      check_value("b2b_ready", int'(s_ready), 1);
      @(posedge clk);
      #1 s_valid = 1'b0;
      @(negedge clk);
      check_value("b2b_valid2", int'(m_valid), 1);
      check_value("b2b_bits2", int'(m_bits), 13);

      // +5 stalled for five cycles
      @(posedge clk);
      #1 m_ready = 1'b0;
      drive_symbol(5);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_value("stall_bits", int'(m_bits), 15);
         check_value("stall_valid", int'(m_valid), 1);
         @(posedge clk);
      end
      #1 m_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_value("p5_b2_bits", int'(m_bits), 4);
      check_value("p5_b2_len", int'(m_len), 3);

      // reset in the middle of -8, then +2 must come out clean
      @(posedge clk);
      #1;
      drive_symbol(-8);
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      #1;
      check_value("mid_rst_valid", int'(m_valid), 0);
      check_value("mid_rst_bits", int'(m_bits), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      drive_symbol(2);
      @(negedge clk);
      check_value("post_rst_bits", int'(m_bits), 12);
      check_value("post_rst_len", int'(m_len), 4);
      check_value("post_rst_last", int'(m_last), 1);

      // random symbols with random gaps and backpressure
      @(posedge clk);
      #1;
      collect = 1'b1;
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         drive_symbol($urandom_range(0, 15) - 8);
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #2 m_ready = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_value("drain_left", exp_q.size(), 0);
      collect = 1'b0;

      decode_stream(dec);
      check_value("loop_count", dec.size(), sent_q.size());
      for (int i = 0; i < sent_q.size() && i < dec.size(); i++) begin
         check_value("loop_sym", dec[i], sent_q[i]);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
